stopwatch_bcd_lap: RTL and testbench

Parametrised BCD stopwatch with start/stop control, lap capture and rollover handling. It adds an internal prescaler, a configurable number of seconds digits, a run/pause state machine, a lap snapshot register and a selectable wrap or saturate mode. It sits between a free-running system clock and display/readout logic.

---
 rtl/stopwatch_bcd_lap.sv | 120 ++++++++++++
 tb/tb_stopwatch_bcd_lap.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_bcd_lap.sv
// BCD stopwatch with run/pause control, lap snapshot and wrap-or-saturate rollover.
// The hundredths tick comes from an internal prescaler that only advances while running.
//
//   state  | meaning
//   IDLE   | counts zero, waiting for start_stop
//   RUN    | prescaler advancing, digits count on tick
//   PAUSED | counts and prescaler fraction held
//   SAT    | frozen at all-nines (SATURATE=1 only), left only by clear/reset
module stopwatch_bcd_lap #(
  parameter int CLK_DIV        = 4,
  parameter int NUM_SEC_DIGITS = 2,
  parameter int SATURATE       = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_stop,
  input  logic                        clear,
  input  logic                        lap,
  output logic                        running,
  output logic [3:0]                  hundredth,
  output logic [3:0]                  tenth,
  output logic [4*NUM_SEC_DIGITS-1:0] sec,
  output logic [3:0]                  lap_hundredth,
  output logic [3:0]                  lap_tenth,
  output logic [4*NUM_SEC_DIGITS-1:0] lap_sec,
  output logic                        lap_valid,
  output logic                        overflow
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int ND = NUM_SEC_DIGITS + 2;

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, SAT} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   pre;
  logic [3:0]      dig     [ND];
  logic [3:0]      dig_nxt [ND];
  logic [3:0]      lap_dig [ND];
  logic            tick;
  logic            wrap;
  logic            nxt_all_nines;
  logic            reach_full;

  assign tick       = (state == RUN) && (pre == PW'(CLK_DIV - 1));
  assign reach_full = tick && nxt_all_nines;

  // digit 0 = hundredths, 1 = tenths, 2.. = seconds (least significant first)
  always_comb begin
    logic c;
    c             = tick;
    nxt_all_nines = 1'b1;
    for (int i = 0; i < ND; i++) begin
      dig_nxt[i] = dig[i];
      if (c) dig_nxt[i] = (dig[i] == 4'd9) ? 4'd0 : dig[i] + 4'd1;
      c = c && (dig[i] == 4'd9);
      if (dig_nxt[i] != 4'd9) nxt_all_nines = 1'b0;
    end
    wrap = c;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_stop) state_nxt = RUN;
      RUN: begin
        if ((SATURATE != 0) && reach_full) state_nxt = SAT;
        else if (start_stop)               state_nxt = PAUSED;
      end
      PAUSED:  if (start_stop) state_nxt = RUN;
      SAT:     state_nxt = SAT;
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      pre       <= '0;
      lap_valid <= 1'b0;
      overflow  <= 1'b0;
      for (int i = 0; i < ND; i++) begin
        dig[i]     <= '0;
        lap_dig[i] <= '0;
      end
    end else begin
      if (state == RUN) pre <= tick ? '0 : pre + PW'(1);
      if (tick) begin
        for (int i = 0; i < ND; i++) dig[i] <= dig_nxt[i];
      end
      // in saturate mode the all-nines state is never ticked past, so wrap stays low
      if (wrap || ((SATURATE != 0) && reach_full)) overflow <= 1'b1;
      // snapshot takes the pre-increment value when a tick lands on the same cycle
      if (lap && (state != IDLE)) begin
        lap_valid <= 1'b1;
        for (int i = 0; i < ND; i++) lap_dig[i] <= dig[i];
      end
    end
  end

  always_comb begin
    running       = (state == RUN);
    hundredth     = dig[0];
    tenth         = dig[1];
    lap_hundredth = lap_dig[0];
    lap_tenth     = lap_dig[1];
    sec           = '0;
    lap_sec       = '0;
    for (int i = 0; i < NUM_SEC_DIGITS; i++) begin
      sec[4*i +: 4]     = dig[2+i];
      lap_sec[4*i +: 4] = lap_dig[2+i];
    end
  end

endmodule

// File: tb/tb_stopwatch_bcd_lap.sv
// Bench for stopwatch_bcd_lap: three instances with different parameters, each tracked by
// a model that keeps time as a plain hundredths count; outputs compared every cycle.
module tb_stopwatch_bcd_lap;

  localparam int ST_IDLE = 0, ST_RUN = 1, ST_PAUSED = 2, ST_SAT = 3;

  int DIV  [3] = '{4, 1, 1};
  int NSD  [3] = '{2, 1, 1};
  int SATP [3] = '{0, 0, 1};

  logic clk, reset;
  logic ss [3];
  logic cl [3];
  logic lp [3];

  logic       run_o [3];
  logic [3:0] hun   [3];
  logic [3:0] ten   [3];
  logic [3:0] lhun  [3];
  logic [3:0] lten  [3];
  logic       lv    [3];
  logic       ovf   [3];
  logic [7:0] sec0, lsec0;
  logic [3:0] sec1, lsec1, sec2, lsec2;

  int m_st [3], m_frac [3], m_cnt [3], m_lap [3];
  bit m_lv [3], m_ovf [3];

  int checks = 0;
  int failures = 0;
  bit chk_on = 0;

  stopwatch_bcd_lap #(.CLK_DIV(4), .NUM_SEC_DIGITS(2), .SATURATE(0)) dut0 (
    .clk(clk), .reset(reset), .start_stop(ss[0]), .clear(cl[0]), .lap(lp[0]),
    .running(run_o[0]), .hundredth(hun[0]), .tenth(ten[0]), .sec(sec0),
    .lap_hundredth(lhun[0]), .lap_tenth(lten[0]), .lap_sec(lsec0),
    .lap_valid(lv[0]), .overflow(ovf[0]));

  stopwatch_bcd_lap #(.CLK_DIV(1), .NUM_SEC_DIGITS(1), .SATURATE(0)) dut1 (
    .clk(clk), .reset(reset), .start_stop(ss[1]), .clear(cl[1]), .lap(lp[1]),
    .running(run_o[1]), .hundredth(hun[1]), .tenth(ten[1]), .sec(sec1),
    .lap_hundredth(lhun[1]), .lap_tenth(lten[1]), .lap_sec(lsec1),
    .lap_valid(lv[1]), .overflow(ovf[1]));

  stopwatch_bcd_lap #(.CLK_DIV(1), .NUM_SEC_DIGITS(1), .SATURATE(1)) dut2 (
    .clk(clk), .reset(reset), .start_stop(ss[2]), .clear(cl[2]), .lap(lp[2]),
    .running(run_o[2]), .hundredth(hun[2]), .tenth(ten[2]), .sec(sec2),
    .lap_hundredth(lhun[2]), .lap_tenth(lten[2]), .lap_sec(lsec2),
    .lap_valid(lv[2]), .overflow(ovf[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int p10(int n);
    int r = 1;
    for (int j = 0; j < n; j++) r = r * 10;
    return r;
  endfunction

  function automatic int sec_bcd(int cnt, int nsd);
    int s = cnt / 100;
    int r = 0;
    for (int j = 0; j < nsd; j++) r = r | (((s / p10(j)) % 10) << (4 * j));
    return r;
  endfunction

  function automatic int act_sec(int k, bit lapsel);
    if (k == 0) return lapsel ? int'(lsec0) : int'(sec0);
    if (k == 1) return lapsel ? int'(lsec1) : int'(sec1);
    return lapsel ? int'(lsec2) : int'(sec2);
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(int k);
    int full, nst;
    bit tick;
    full = p10(NSD[k]) * 100 - 1;
    if (reset || cl[k]) begin
      m_st[k] = ST_IDLE; m_frac[k] = 0; m_cnt[k] = 0; m_lap[k] = 0;
      m_lv[k] = 0; m_ovf[k] = 0;
    end else begin
      tick = (m_st[k] == ST_RUN) && (m_frac[k] == DIV[k] - 1);
      if (lp[k] && m_st[k] != ST_IDLE) begin
        m_lap[k] = m_cnt[k];
        m_lv[k]  = 1;
      end
      if (m_st[k] == ST_RUN) m_frac[k] = tick ? 0 : m_frac[k] + 1;
      nst = m_st[k];
      if (ss[k]) begin
        if (m_st[k] == ST_IDLE || m_st[k] == ST_PAUSED) nst = ST_RUN;
        else if (m_st[k] == ST_RUN) nst = ST_PAUSED;
      end
      if (tick) begin
        if (m_cnt[k] == full) begin
          m_cnt[k] = 0;
          m_ovf[k] = 1;
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
          if (SATP[k] != 0 && m_cnt[k] == full) begin
            nst = ST_SAT;
            m_ovf[k] = 1;
          end
        end
      end
      m_st[k] = nst;
    end
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) model_step(k);
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("d%0d_running", k), int'(run_o[k]), int'(m_st[k] == ST_RUN));
        chk($sformatf("d%0d_hundredth", k), int'(hun[k]), m_cnt[k] % 10);
        chk($sformatf("d%0d_tenth", k), int'(ten[k]), (m_cnt[k] / 10) % 10);
        chk($sformatf("d%0d_sec", k), act_sec(k, 0), sec_bcd(m_cnt[k], NSD[k]));
        chk($sformatf("d%0d_lap_hundredth", k), int'(lhun[k]), m_lap[k] % 10);
        chk($sformatf("d%0d_lap_tenth", k), int'(lten[k]), (m_lap[k] / 10) % 10);
        chk($sformatf("d%0d_lap_sec", k), act_sec(k, 1), sec_bcd(m_lap[k], NSD[k]));
        chk($sformatf("d%0d_lap_valid", k), int'(lv[k]), int'(m_lv[k]));
        chk($sformatf("d%0d_overflow", k), int'(ovf[k]), int'(m_ovf[k]));
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_ss(int k);
    ss[k] = 1'b1; @(negedge clk); ss[k] = 1'b0;
  endtask

  task automatic pulse_cl(int k);
    cl[k] = 1'b1; @(negedge clk); cl[k] = 1'b0;
  endtask

  task automatic pulse_lp(int k);
    lp[k] = 1'b1; @(negedge clk); lp[k] = 1'b0;
  endtask

  task automatic expect_time(string name, int k, int h, int t, int s, int r);
    chk({name, "_h"}, int'(hun[k]), h);
    chk({name, "_t"}, int'(ten[k]), t);
    chk({name, "_s"}, act_sec(k, 0), s);
    chk({name, "_run"}, int'(run_o[k]), r);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      ss[k] = 1'b0; cl[k] = 1'b0; lp[k] = 1'b0;
    end
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    chk_on = 1'b1;

    // reset state
    expect_time("rst_d0", 0, 0, 0, 0, 0);
    chk("rst_lap_valid", int'(lv[0]), 0);
    chk("rst_overflow", int'(ovf[0]), 0);

    // 40 run cycles at CLK_DIV=4 -> 10 ticks
    pulse_ss(0);
    cyc(40);
    expect_time("run40", 0, 0, 1, 0, 1);

    // pause keeps the prescaler fraction
    pulse_cl(0);
    expect_time("clr_d0", 0, 0, 0, 0, 0);
    pulse_ss(0);
    cyc(10);
    chk("run10_h", int'(hun[0]), 2);
    pulse_ss(0);
    cyc(20);
    expect_time("paused", 0, 2, 0, 0, 0);
    pulse_ss(0);
    cyc(8);
    expect_time("resume8", 0, 4, 0, 0, 1);

    // start_stop + lap on a tick cycle: tick applied, lap takes the old value, then paused
    ss[0] = 1'b1; lp[0] = 1'b1;
    @(negedge clk);
    ss[0] = 1'b0; lp[0] = 1'b0;
    expect_time("ss_lap_tick", 0, 5, 0, 0, 0);
    chk("ss_lap_lh", int'(lhun[0]), 4);
    chk("ss_lap_lv", int'(lv[0]), 1);

    // wrap mode rollover, CLK_DIV=1
    pulse_ss(1);
    cyc(999);
    expect_time("wrap999", 1, 9, 9, 9, 1);
    chk("wrap999_ovf", int'(ovf[1]), 0);
    cyc(1);
    expect_time("wrap1000", 1, 0, 0, 0, 1);
    chk("wrap1000_ovf", int'(ovf[1]), 1);

    // saturate mode
    pulse_ss(2);
    cyc(999);
    expect_time("sat999", 2, 9, 9, 9, 0);
    chk("sat999_ovf", int'(ovf[2]), 1);
    cyc(6);
    pulse_ss(2);
    cyc(2);
    expect_time("sat_hold", 2, 9, 9, 9, 0);
    pulse_cl(2);
    expect_time("sat_clr", 2, 0, 0, 0, 0);
    chk("sat_clr_ovf", int'(ovf[2]), 0);

    // lap: ignored in IDLE, pre-increment capture on a tick
    pulse_cl(1);
    pulse_lp(1);
    chk("idle_lap_lv", int'(lv[1]), 0);
    pulse_ss(1);
    cyc(37);
    expect_time("at037", 1, 7, 3, 0, 1);
    pulse_lp(1);
    expect_time("live038", 1, 8, 3, 0, 1);
    chk("lap037_h", int'(lhun[1]), 7);
    chk("lap037_t", int'(lten[1]), 3);
    chk("lap037_s", act_sec(1, 1), 0);
    chk("lap037_lv", int'(lv[1]), 1);

    // clear wins over start_stop
    pulse_ss(0);
    cyc(5);
    ss[0] = 1'b1; cl[0] = 1'b1;
    @(negedge clk);
    ss[0] = 1'b0; cl[0] = 1'b0;
    expect_time("clr_ss", 0, 0, 0, 0, 0);
    chk("clr_ss_lv", int'(lv[0]), 0);
    cyc(3);
    expect_time("clr_ss_idle", 0, 0, 0, 0, 0);

    // reset mid-count, then no residual prescaler fraction
    pulse_ss(0);
    cyc(6);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    expect_time("rst_mid_d1", 1, 0, 0, 0, 0);
    chk("rst_mid_lv", int'(lv[1]), 0);
    expect_time("rst_mid_d0", 0, 0, 0, 0, 0);
    pulse_ss(0);
    cyc(3);
    chk("post_rst_h3", int'(hun[0]), 0);
    cyc(1);
    chk("post_rst_h4", int'(hun[0]), 1);

    cyc(2);
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
